// File: rtl/param_datapath_core.sv
// Parametrised register-file / function-unit datapath with a req/ack memory port, one op at a time.
// Latency: accept->done 2 cycles (ALU op), plus 1 cycle and the ack wait for memory ops.
// Backpressure: op_ready is high only in IDLE; memory strobes hold until mem_ack (or timeout).
// Optional feature macro: DATAPATH_MEM_TIMEOUT_EN (memory ack timeout with sticky err).
module param_datapath_core #(
    parameter int WIDTH       = 16,
    parameter int NREGS       = 8,
    parameter int TIMEOUT_CYC = 15,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic             clock_50,
    input  logic             clear_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [AW-1:0]    AA,
    input  logic [AW-1:0]    BA,
    input  logic [AW-1:0]    DA,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] k,
    input  logic             MB,
    input  logic             MA,
    input  logic             MD,
    input  logic             MW,
    input  logic             WR,
    input  logic             Cin,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_re,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             V,
    output logic             N,
    output logic             Z,
    output logic             done,
    output logic             err,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sd_q, sd_d, maddr_q, maddr_d, ld_q, ld_d;
    logic [AW-1:0]    da_q, da_d;
    logic [4:0]       fs_q, fs_d;
    logic             cin_q, cin_d, md_q, md_d, mw_q, mw_d, wr_q, wr_d;
    logic [WIDTH-1:0] f_q, f_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic             cout_q, cout_d, v_q, v_d, n_q, n_d, z_q, z_d, done_q, done_d;
    logic             mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic             timed_out;

    // Function unit operands / results
    logic [WIDTH-1:0] add_x;
    logic             add_c;
    logic             is_arith;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] alu_f;
    logic             alu_c, alu_v;

`ifdef DATAPATH_MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    assign timed_out = err_q;
    assign err       = err_q;
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    assign op_ready  = (state_q == S_IDLE);
    assign dbg_data  = rf_q[dbg_addr];
    assign F         = f_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign done      = done_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Function unit: all arithmetic codes share one adder as A + X + c
    always_comb begin
        add_x    = '0;
        add_c    = 1'b0;
        is_arith = 1'b0;
        case (fs_q)
            5'b00000: begin add_x = '0;    add_c = cin_q; is_arith = 1'b1; end
            5'b00001: begin add_x = b_q;   add_c = cin_q; is_arith = 1'b1; end
            5'b00010: begin add_x = ~b_q;  add_c = 1'b1;  is_arith = 1'b1; end
            5'b00011: begin add_x = '1;    add_c = 1'b0;  is_arith = 1'b1; end
            default:  ;
        endcase
        add_sum = {1'b0, a_q} + {1'b0, add_x} + {{WIDTH{1'b0}}, add_c};
        alu_f   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (is_arith) begin
            alu_f = add_sum[WIDTH-1:0];
            alu_c = add_sum[WIDTH];
            alu_v = (a_q[WIDTH-1] == add_x[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
            case (fs_q)
                5'b00100: alu_f = a_q & b_q;
                5'b00101: alu_f = a_q | b_q;
                5'b00110: alu_f = a_q ^ b_q;
                5'b00111: alu_f = ~a_q;
                5'b01000: alu_f = b_q;
                5'b01001: begin alu_f = {a_q[WIDTH-2:0], 1'b0};      alu_c = a_q[WIDTH-1]; end
                5'b01010: begin alu_f = {1'b0, a_q[WIDTH-1:1]};      alu_c = a_q[0];       end
                5'b01011: begin alu_f = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; alu_c = a_q[0];    end
                default:  alu_f = '0;
            endcase
        end
    end

    // Sequencer: IDLE -> EXEC -> (MEM) -> WB -> IDLE, computing every next-state value
    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        a_d         = a_q;
        b_d         = b_q;
        sd_d        = sd_q;
        maddr_d     = maddr_q;
        ld_d        = ld_q;
        da_d        = da_q;
        fs_d        = fs_q;
        cin_d       = cin_q;
        md_d        = md_q;
        mw_d        = mw_q;
        wr_d        = wr_q;
        f_d         = f_q;
        cout_d      = cout_q;
        v_d         = v_q;
        n_d         = n_q;
        z_d         = z_q;
        done_d      = 1'b0;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef DATAPATH_MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    a_d     = rf_q[AA];
                    b_d     = MB ? k : rf_q[BA];
                    sd_d    = rf_q[BA];
                    maddr_d = MA ? k : rf_q[AA];
                    da_d    = DA;
                    fs_d    = FS;
                    cin_d   = Cin;
                    mw_d    = MW;
                    md_d    = MD && !MW;   // store wins when both are requested
                    wr_d    = WR;
`ifdef DATAPATH_MEM_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                f_d    = alu_f;
                cout_d = alu_c;
                v_d    = alu_v;
                n_d    = alu_f[WIDTH-1];
                z_d    = (alu_f == '0);
                if (md_q || mw_q) begin
                    mem_addr_d = maddr_q;
                    mem_re_d   = md_q;
                    mem_we_d   = mw_q;
                    if (mw_q) mem_wdata_d = sd_q;
`ifdef DATAPATH_MEM_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                    state_d    = S_MEM;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (md_q) ld_d = mem_rdata;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_WB;
                end
`ifdef DATAPATH_MEM_TIMEOUT_EN
                else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_WB: begin
                if (wr_q && !timed_out) rf_d[da_q] = md_q ? ld_q : f_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight op immediately
    always_ff @(posedge clock_50 or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= S_IDLE;
            rf_q        <= '{default: '0};
            a_q         <= '0;
            b_q         <= '0;
            sd_q        <= '0;
            maddr_q     <= '0;
            ld_q        <= '0;
            da_q        <= '0;
            fs_q        <= '0;
            cin_q       <= 1'b0;
            md_q        <= 1'b0;
            mw_q        <= 1'b0;
            wr_q        <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            done_q      <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sd_q        <= sd_d;
            maddr_q     <= maddr_d;
            ld_q        <= ld_d;
            da_q        <= da_d;
            fs_q        <= fs_d;
            cin_q       <= cin_d;
            md_q        <= md_d;
            mw_q        <= mw_d;
            wr_q        <= wr_d;
            f_q         <= f_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            n_q         <= n_d;
            z_q         <= z_d;
            done_q      <= done_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef DATAPATH_MEM_TIMEOUT_EN
    // Memory wait counter and sticky timeout flag
    always_ff @(posedge clock_50 or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_param_datapath_core.sv
// Scoreboarded random + directed bench for param_datapath_core.
// Expected results come from an integer-arithmetic model of the operation rules.
// A memory responder process supplies acks with per-op programmed delay.
module tb_param_datapath_core;
    localparam int W  = 16;
    localparam int NR = 8;
    localparam int TO = 15;
    localparam int AW = 3;
`ifdef DATAPATH_MEM_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif
    localparam longint MASK = (64'd1 << W) - 1;
    localparam longint HALF = 64'd1 << (W - 1);
    localparam longint SMAX = HALF - 1;
    localparam longint SMIN = -HALF;

    logic clock_50 = 1'b0, clear_n = 1'b0;
    logic op_valid = 1'b0, op_ready;
    logic [AW-1:0] AA = '0, BA = '0, DA = '0, dbg_addr = '0;
    logic [4:0] FS = '0;
    logic [W-1:0] k = '0, mem_addr, mem_wdata, mem_rdata = '0, F, dbg_data;
    logic MB = 0, MA = 0, MD = 0, MW = 0, WR = 0, Cin = 0;
    logic mem_re, mem_we, mem_ack = 1'b0;
    logic Cout, V, N, Z, done, err;

    param_datapath_core #(.WIDTH(W), .NREGS(NR), .TIMEOUT_CYC(TO)) dut (
        .clock_50(clock_50), .clear_n(clear_n), .op_valid(op_valid), .op_ready(op_ready),
        .AA(AA), .BA(BA), .DA(DA), .FS(FS), .k(k), .MB(MB), .MA(MA), .MD(MD), .MW(MW),
        .WR(WR), .Cin(Cin), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .F(F), .Cout(Cout),
        .V(V), .N(N), .Z(Z), .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

    always #5 clock_50 = ~clock_50;

    typedef struct {
        longint f;
        bit cout, v, n, z, err;
    } exp_t;

    exp_t   sb_q[$];
    longint mreg[NR];
    int     n_checks = 0, n_errs = 0;
    int     acc_cnt = 0, strobe_cnt = 0, wcnt = 0;
    int     rsp_delay = 0;
    longint rsp_data = 0;
    bit     exp_re = 0, exp_we = 0;
    longint exp_addr = 0, exp_wdata = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint sgn(input longint x);
        return (x >= HALF) ? x - (MASK + 1) : x;
    endfunction

    // Operation rules written directly as integer arithmetic
    function automatic exp_t model(input int fs, input longint a, input longint b, input int cin);
        exp_t e;
        longint u, s;
        bit arith;
        e.f = 0; e.cout = 0; e.v = 0; e.err = 0;
        u = 0; s = 0; arith = 1;
        case (fs)
            0: begin u = a + cin;              s = sgn(a) + cin;          end
            1: begin u = a + b + cin;          s = sgn(a) + sgn(b) + cin; end
            2: begin u = a + (MASK - b) + 1;   s = sgn(a) - sgn(b);       end
            3: begin u = a + MASK;             s = sgn(a) - 1;            end
            default: arith = 0;
        endcase
        if (arith) begin
            e.f    = u & MASK;
            e.cout = ((u >> W) & 1) != 0;
            e.v    = (s > SMAX) || (s < SMIN);
        end else begin
            case (fs)
                4:  e.f = a & b;
                5:  e.f = a | b;
                6:  e.f = a ^ b;
                7:  e.f = MASK - a;
                8:  e.f = b;
                9:  begin e.f = (a * 2) & MASK;           e.cout = a >= HALF;  end
                10: begin e.f = a / 2;                    e.cout = a % 2 == 1; end
                11: begin e.f = (a / 2) + (a & HALF);     e.cout = a % 2 == 1; end
                default: e.f = 0;
            endcase
        end
        e.z = (e.f == 0);
        e.n = e.f >= HALF;
        return e;
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry
    always @(negedge clock_50) begin
        exp_t e;
        if (clear_n && done) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_F", F, e.f);
                chk("sb_Cout", Cout, e.cout);
                chk("sb_V", V, e.v);
                chk("sb_N", N, e.n);
                chk("sb_Z", Z, e.z);
                chk("sb_err", err, e.err);
            end
        end
    end

    // Count op handshakes (inputs are stable at the falling edge)
    always @(negedge clock_50) begin
        if (clear_n && op_valid && op_ready) acc_cnt++;
    end

    // Memory responder: acks after rsp_delay strobe cycles, random acks while idle
    always @(negedge clock_50) begin
        if (!clear_n) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_re || mem_we) begin
            strobe_cnt++;
            chk("mem_re", mem_re, exp_re);
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            if (mem_we) chk("mem_wdata", mem_wdata, exp_wdata);
            if (wcnt == rsp_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = W'(rsp_data);
            end else begin
                mem_ack   = 1'b0;
            end
            wcnt++;
        end else begin
            wcnt      = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = W'($urandom);
        end
    end

    // Issue one op from IDLE (called #1 after a rising edge) and follow it to completion
    task automatic run_op(input int aa, input int ba, input int da, input int fs, input longint kk,
                          input int mb, input int ma, input int md, input int mw, input int wr,
                          input int cin, input int dly, input longint rdat, input bit hold);
        exp_t e;
        longint a, b;
        bit to, mem, got;
        int cyc, expcyc;
        a   = mreg[aa];
        b   = mb ? kk : mreg[ba];
        e   = model(fs, a, b, cin);
        mem = (md != 0) || (mw != 0);
        to  = TO_ON && mem && (dly >= TO);
        e.err = to;
        sb_q.push_back(e);
        exp_re = (md != 0) && (mw == 0);
        exp_we = (mw != 0);
        exp_addr  = ma ? kk : a;
        exp_wdata = mreg[ba];
        rsp_delay = dly;
        rsp_data  = rdat;
        strobe_cnt = 0;
        AA = AW'(aa); BA = AW'(ba); DA = AW'(da); FS = 5'(fs); k = W'(kk);
        MB = mb[0]; MA = ma[0]; MD = md[0]; MW = mw[0]; WR = wr[0]; Cin = cin[0];
        op_valid = 1'b1;
        @(posedge clock_50);
        #1;
        if (!hold) op_valid = 1'b0;
        cyc = 0;
        got = 0;
        while (!got && cyc < 200) begin
            @(negedge clock_50);
            cyc++;
            if (done) got = 1;
        end
        op_valid = 1'b0;
        chk("done_seen", got, 1);
        expcyc = !mem ? 2 : (to ? TO + 2 : dly + 3);
        chk("done_latency", cyc, expcyc);
        if (mem) chk("strobe_cycles", strobe_cnt, to ? TO : dly + 1);
        if (wr != 0 && !to) mreg[da] = exp_re ? (rdat & MASK) : e.f;
        @(posedge clock_50);
        #1;
        dbg_addr = AW'(da);
        #1;
        chk("dbg_reg", dbg_data, mreg[da]);
        chk("ready_after", op_ready, 1);
    endtask

    initial begin
        bit got;
        for (int i = 0; i < NR; i++) mreg[i] = 0;
        #12;
        chk("rst_ready", op_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_F", F, 0);
        chk("rst_strobes", {mem_re, mem_we}, 0);
        chk("rst_err", err, 0);
        chk("rst_dbg", dbg_data, 0);
        @(negedge clock_50);
        clear_n = 1'b1;
        @(posedge clock_50);
        #1;

        // Preload and directed arithmetic cases
        run_op(0, 0, 1, 8, 64'h7FFF, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_op(0, 0, 2, 8, 64'h0001, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_op(1, 2, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("add_F", F, 16'h8000);
        chk("add_V", V, 1);
        chk("add_N", N, 1);
        chk("add_Cout", Cout, 0);
        chk("add_Z", Z, 0);
        run_op(0, 0, 4, 8, 64'h1234, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_op(4, 4, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sub_F", F, 0);
        chk("sub_Z", Z, 1);
        chk("sub_Cout", Cout, 1);
        run_op(0, 0, 6, 8, 64'h8001, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_op(6, 0, 7, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("asr_F", F, 16'hC000);
        chk("asr_Cout", Cout, 1);

        // Load with ack in the third strobe cycle, then a back-to-back reader of R5
        run_op(0, 0, 5, 0, 64'h0040, 0, 1, 1, 0, 1, 0, 2, 64'hBEEF, 0);
        run_op(5, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("b2b_F", F, 16'hBEEF);

        // Store with op_valid held high throughout: exactly one accept
        run_op(0, 0, 0, 8, 64'h00AA, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        acc_cnt = 0;
        run_op(1, 0, 2, 4, 0, 0, 0, 0, 1, 0, 0, 3, 0, 1);
        chk("hold_accepts", acc_cnt, 1);

        // Randomised ops, including loads/stores and undefined function codes
        for (int i = 0; i < 40; i++) begin
            int md, mw;
            md = ($urandom_range(0, 3) == 0);
            mw = ($urandom_range(0, 3) == 0);
            run_op($urandom_range(0, NR - 1), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                   $urandom_range(0, 15), longint'($urandom) & MASK, $urandom_range(0, 1),
                   $urandom_range(0, 1), md, mw, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 4), longint'($urandom) & MASK, 0);
        end

`ifdef DATAPATH_MEM_TIMEOUT_EN
        // Load that never gets an ack: timeout, err, no writeback
        run_op(1, 0, 2, 0, 64'h0100, 0, 1, 1, 0, 1, 0, 1000, 64'h5555, 0);
        chk("to_err_sticky", err, 1);
        // Ack in the timeout cycle itself wins
        run_op(1, 0, 3, 0, 64'h0100, 0, 1, 1, 0, 1, 0, TO - 1, 64'h1357, 0);
        chk("to_ack_wins_reg", mreg[3], 64'h1357);
`endif

        // Reset while a store is waiting in MEM
        exp_re = 0; exp_we = 1; exp_addr = 64'h0033; exp_wdata = mreg[4];
        rsp_delay = 100000; strobe_cnt = 0;
        AA = 0; BA = 4; DA = 1; FS = 0; k = 16'h0033;
        MB = 0; MA = 1; MD = 0; MW = 1; WR = 1; Cin = 0;
        op_valid = 1'b1;
        @(posedge clock_50);
        #1;
        op_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock_50);
            if (mem_we) got = 1;
        end
        chk("rst_mem_we_seen", got, 1);
        #2;
        clear_n = 1'b0;
        #1;
        chk("arst_mem_we", mem_we, 0);
        chk("arst_ready", op_ready, 1);
        chk("arst_F", F, 0);
        chk("arst_done", done, 0);
        for (int r = 0; r < NR; r++) begin
            dbg_addr = AW'(r);
            #0.1;
            chk("arst_reg", dbg_data, 0);
            mreg[r] = 0;
        end
        #1;
        clear_n = 1'b1;
        @(posedge clock_50);
        #1;
        run_op(0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        chk("post_rst_R3", dbg_data, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
